// File: rtl/imu_stream_tx.sv
// IMU sample transmitter: buffers up to SEQ_LEN samples, then replays them
// as one framed valid/ready stream with sof/eof markers and optional gaps.
module imu_stream_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEQ_LEN    = 16,
  parameter int unsigned GAP_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_full,
  output logic                         wr_overflow,
  output logic [$clog2(SEQ_LEN+1)-1:0] buf_count,
  input  logic                         start,
  input  logic [GAP_W-1:0]             gap_cycles,
  output logic [DATA_WIDTH-1:0]        imu_data,
  output logic                         valid,
  input  logic                         ready,
  output logic                         sof,
  output logic                         eof,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  tx_count
);

  localparam int unsigned CW = $clog2(SEQ_LEN + 1);
  localparam int unsigned IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [GAP_W-1:0]      gcnt_q, gcnt_d;
  logic [15:0]           tx_q, tx_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] mem_q [SEQ_LEN];

  // Outputs decode directly from registered state, so they hold while stalled
  assign valid       = (state_q == S_SEND);
  assign imu_data    = valid ? mem_q[rd_idx_q] : '0;
  assign sof         = valid && (rd_idx_q == '0);
  assign eof         = valid && (CW'(rd_idx_q) == (cnt_q - CW'(1)));
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign wr_full     = (cnt_q == CW'(SEQ_LEN));
  assign wr_overflow = ovf_q;
  assign buf_count   = cnt_q;
  assign tx_count    = tx_q;

  // Sample buffer; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_idx_q <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      tx_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_idx_q <= rd_idx_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Buffer load handling and frame sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_idx_d  = rd_idx_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    tx_d      = tx_q;
    ovf_d     = 1'b0;
    wr_accept = 1'b0;

    if (wr_en) begin
      if (state_q == S_IDLE && !wr_full) begin
        wr_accept = 1'b1;
        wr_ptr_d  = wr_ptr_q + IW'(1);
        cnt_d     = cnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        // Start decision uses the count before any same-cycle write lands
        if (start && cnt_q != '0) begin
          state_d  = S_SEND;
          rd_idx_d = '0;
          gap_d    = gap_cycles;
        end
      end
      S_SEND: begin
        if (ready) begin
          tx_d = tx_q + 16'd1;
          if (eof) begin
            state_d = S_DONE;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
            if (gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q <= GAP_W'(1)) state_d = S_SEND;
      end
      S_DONE: begin
        cnt_d    = '0;
        wr_ptr_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imu_stream_tx.sv
// Self-checking bench for imu_stream_tx: scoreboard of expected samples
// consumed by a handshake monitor, plus per-scenario timing checks.
module tb_imu_stream_tx;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, ready;
  logic [15:0] wr_data;
  logic [7:0]  gap_cycles;
  logic        wr_full, wr_overflow, valid, sof, eof, busy, done;
  logic [4:0]  buf_count;
  logic [15:0] imu_data, tx_count;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        push_e;
  logic [15:0] ld[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          mtx = 0;
  int          start_cyc = 0;

  imu_stream_tx #(.DATA_WIDTH(16), .SEQ_LEN(16), .GAP_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_overflow(wr_overflow), .buf_count(buf_count),
    .start(start), .gap_cycles(gap_cycles), .imu_data(imu_data),
    .valid(valid), .ready(ready), .sof(sof), .eof(eof), .busy(busy),
    .done(done), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard consumer: every handshake must match the next expected sample
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      hs_cyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got data=%h sof=%b eof=%b, required no handshake",
                 imu_data, sof, eof);
      end else begin
        mon_e = exp_q.pop_front();
        if ({imu_data, sof, eof} !== {mon_e.d, mon_e.sof, mon_e.eof}) begin
          miscompares++;
          $display("FAIL sb_sample: got data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                   imu_data, sof, eof, mon_e.d, mon_e.sof, mon_e.eof);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    ld.push_back(v);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] gap);
    for (int i = 0; i < ld.size(); i++) begin
      push_e.d   = ld[i];
      push_e.sof = (i == 0);
      push_e.eof = (i == ld.size() - 1);
      exp_q.push_back(push_e);
    end
    mtx        = mtx + ld.size();
    ld.delete();
    gap_cycles = gap;
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or after 50 cycles without it
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({valid, sof, eof, busy, done, wr_full, wr_overflow, buf_count, tx_count, imu_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b full=%b ovf=%b cnt=%0d tx=%0d data=%h, required all zero",
               valid, busy, done, wr_full, wr_overflow, buf_count, tx_count, imu_data);
    end
    tick();
  endtask

  task automatic test_basic;
    int n;
    ready = 1'b1;
    load(16'd10); load(16'd20); load(16'd30); load(16'd40);
    start_frame(8'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({valid, sof, eof} !== {1'b1, k == 0, k == 3}) begin
        miscompares++;
        $display("FAIL basic_frame[%0d]: got valid=%b sof=%b eof=%b, required valid=1 sof=%b eof=%b",
                 k, valid, sof, eof, k == 0, k == 3);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if ({done, valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b valid=%b, required done=1 valid=0", done, valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({tx_count, buf_count, busy, done} !== {16'(mtx), 5'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_after: got tx=%0d cnt=%0d busy=%b done=%b, required tx=%0d cnt=0 busy=0 done=0",
               tx_count, buf_count, busy, done, mtx);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain: got %0d samples pending, required 0", exp_q.size());
    end
    n = 0;
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    ready = 1'b1;
    load(16'd10); load(16'd20); load(16'd30); load(16'd40);
    start_frame(8'd0);
    tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({valid, imu_data} !== {1'b1, 16'd20}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%0d, required valid=1 data=20", k, valid, imu_data);
      end
      tick();
    end
    ready = 1'b1;
    wait_done(n);
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL stall_done_timeout: got no done in %0d cycles, required done", n);
    end
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({tx_count, busy} !== {16'(mtx), 1'b0} || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_after: got tx=%0d busy=%b pending=%0d, required tx=%0d busy=0 pending=0",
               tx_count, busy, exp_q.size(), mtx);
    end
    tick();
  endtask

  task automatic test_gap;
    int n;
    int s;
    int dc;
    ready = 1'b1;
    load(16'd1); load(16'd2); load(16'd3);
    hs_cyc.delete();
    start_frame(8'd2);
    s = start_cyc;
    wait_done(n);
    dc = cyc;
    vectors++;
    if (hs_cyc.size() != 3) begin
      miscompares++;
      $display("FAIL gap_count: got %0d handshakes, required 3", hs_cyc.size());
    end else begin
      vectors++;
      if ({hs_cyc[0], hs_cyc[1], hs_cyc[2]} !== {s + 1, s + 4, s + 7}) begin
        miscompares++;
        $display("FAIL gap_timing: got handshakes at +%0d +%0d +%0d, required +1 +4 +7",
                 hs_cyc[0] - s, hs_cyc[1] - s, hs_cyc[2] - s);
      end
    end
    vectors++;
    if (dc != s + 8) begin
      miscompares++;
      $display("FAIL gap_done: got done at +%0d, required +8", dc - s);
    end
    tick();
    tick();
  endtask

  task automatic test_overflow;
    int n;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load(16'(100 + i));
      if (i == 14) begin
        @(negedge clk);
        vectors++;
        if (wr_full !== 1'b0) begin
          miscompares++;
          $display("FAIL full_early: got wr_full=%b at 15 samples, required 0", wr_full);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if ({wr_full, buf_count} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL full_at16: got wr_full=%b cnt=%0d, required wr_full=1 cnt=16", wr_full, buf_count);
    end
    wr_en   = 1'b1;
    wr_data = 16'hFFFF;
    tick();
    wr_en   = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wr_overflow, buf_count} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL ovf_full: got ovf=%b cnt=%0d, required ovf=1 cnt=16", wr_overflow, buf_count);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (wr_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_pulse: got ovf=%b one cycle later, required 0", wr_overflow);
    end
    start_frame(8'd0);
    tick();
    wr_en   = 1'b1;
    wr_data = 16'hDEAD;
    tick();
    wr_en   = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wr_overflow, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL ovf_busy: got ovf=%b busy=%b, required ovf=1 busy=1", wr_overflow, busy);
    end
    wait_done(n);
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (n >= 50 || tx_count !== 16'(mtx) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_frame: got tx=%0d pending=%0d wait=%0d, required tx=%0d pending=0",
               tx_count, exp_q.size(), n, mtx);
    end
    tick();
  endtask

  task automatic test_single;
    ready = 1'b1;
    load(16'hBEEF);
    start_frame(8'd0);
    @(negedge clk);
    vectors++;
    if ({valid, sof, eof, imu_data} !== {3'b111, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL single_sample: got valid=%b sof=%b eof=%b data=%h, required 1 1 1 beef",
               valid, sof, eof, imu_data);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({done, valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_done: got done=%b valid=%b, required done=1 valid=0", done, valid);
    end
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_start: got busy=%b valid=%b, required 0 0", busy, valid);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    ready = 1'b1;
    load(16'd11); load(16'd22); load(16'd33); load(16'd44);
    start_frame(8'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mtx = 0;
    @(negedge clk);
    vectors++;
    if ({valid, busy, buf_count, tx_count, done} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got valid=%b busy=%b cnt=%0d tx=%0d done=%b, required all zero",
               valid, busy, buf_count, tx_count, done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_done[%0d]: got done=%b, required 0", k, done);
      end
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_start_ignored: got busy=%b, required 0", busy);
    end
    tick();
    load(16'd5); load(16'd6);
    start_frame(8'd0);
    wait_done(n);
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (n >= 50 || tx_count !== 16'(mtx) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_reload: got tx=%0d pending=%0d wait=%0d, required tx=%0d pending=0",
               tx_count, exp_q.size(), n, mtx);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    start      = 1'b0;
    ready      = 1'b0;
    gap_cycles = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_overflow();
    test_single();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imu_stream_tx.md
Name: imu_stream_tx

Overview:
IMU sample transmitter. It is the source side of the imu_data/valid stream that the IMU monitor and downstream fusion logic consume. Firmware or a testbench loads up to SEQ_LEN samples into a local buffer; on start, the block replays them as one framed sequence with a valid/ready handshake, frame markers and an optional inter-sample gap. The block is synthesizable and is used both as a bench stimulus source and as an on-chip replay engine.

Parameters:
DATA_WIDTH, 16, width of one IMU sample
SEQ_LEN, 16, buffer depth = maximum samples per frame (>=1)
GAP_W, 8, width of the inter-sample gap counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  buffer write strobe
wr_data  input  DATA_WIDTH  sample to append to buffer
wr_full  output  1  buffer holds SEQ_LEN samples
wr_overflow  output  1  one-cycle pulse: write dropped
buf_count  output  $clog2(SEQ_LEN+1)  samples currently loaded
start  input  1  begin transmitting loaded frame
gap_cycles  input  GAP_W  idle cycles between samples, latched at start
imu_data  output  DATA_WIDTH  current sample
valid  output  1  imu_data valid
ready  input  1  downstream accepts when valid&&ready
sof  output  1  high with first sample of frame
eof  output  1  high with last sample of frame
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after last handshake
tx_count  output  16  total samples handshaken since reset; wraps at 2^16

Behaviour:
- Reset values: all outputs 0, state IDLE, buf_count 0, wr_ptr 0, rd_idx 0, gap counter 0. Buffer RAM contents are not reset.
- Load, IDLE only:
  - wr_en with buf_count<SEQ_LEN: buf[wr_ptr]=wr_data; wr_ptr++ and buf_count++ next cycle.
  - wr_en while full or busy: data discarded; wr_overflow=1 next cycle.
- wr_full is combinational: (buf_count==SEQ_LEN).
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start && buf_count>0 -> SEND next cycle; rd_idx=0; gap_cycles latched.
  - start with buf_count==0 is ignored.
  - Same-cycle wr_en and start: the write is taken, start uses the pre-write count.
- SEND:
  - valid=1; imu_data=buf[rd_idx]; sof=(rd_idx==0); eof=(rd_idx==buf_count-1).
  - Outputs are registered and held stable while valid && !ready.
  - Latency: start at cycle N, first valid at N+1.
- On handshake in SEND:
  - tx_count++.
  - If eof -> DONE.
  - Else if latched gap==0: stay in SEND, rd_idx++, next sample presented the following cycle (back-to-back, one sample per cycle).
  - Else -> GAP with counter=gap; rd_idx++.
- GAP: valid=0; counter decrements each cycle; at 1 -> SEND. valid is low for exactly gap cycles between handshakes.
- DONE: valid=0; done=1 for one cycle; buf_count, wr_ptr cleared (buffer consumed) -> IDLE.
- start during busy: ignored.
- ready is ignored when valid=0.
- Reset asserted in any state: next cycle is the reset state, with no done pulse and the frame abandoned.
- sof and eof are both 1 for a single-sample frame.

Test Plan:
1. SEQ_LEN=16. Load 10,20,30,40; gap 0; ready=1; start at cycle N -> valid cycles N+1..N+4 with data 10,20,30,40; sof only at N+1; eof only at N+4; done at N+5; tx_count=4, buf_count=0, busy=0 at N+6.
2. Same load; ready=0 for 3 cycles while data=20 -> imu_data held at 20, valid stays 1, no duplicate or skip; tx_count ends at 4.
3. Load 1,2,3; gap_cycles=2; ready=1 -> each handshake is followed by exactly 2 valid-low cycles; frame spans 7 cycles; done follows the sample 3 handshake.
4. Write 17 samples -> wr_full=1 after the 16th; the 17th gives a wr_overflow pulse and buf_count stays 16. A write during busy also pulses wr_overflow and does not corrupt the frame.
5. Load single sample 0xBEEF; start -> one valid cycle with sof=eof=1, then done. start with empty buffer -> busy stays 0.
6. rst high mid-frame, during sample 2 of 4 -> next cycle valid=0, busy=0, buf_count=0, tx_count=0, no done pulse; a following start is ignored until the buffer is reloaded.
